// File: rtl/divided_tick_bcd_counter_if.sv
// Control and status bundle for divided_tick_bcd_counter.
// master: the driving side (divider wave, control pulses), observes tick/digits/status.
// slave : the counter itself.
//   DIV_IN  - divided square wave, may be asynchronous to CLK
//   START   - pulse, enter RUNNING
//   STOP    - pulse, enter STOPPED (wins over START)
//   CLEAR   - synchronous zero of both digits
//   UP      - count direction, 1 = up
//   TICK    - one-cycle pulse per DIV_IN rising edge
//   ONES    - BCD ones digit
//   TENS    - BCD tens digit
//   WRAP    - one-cycle pulse on rollover/underflow
//   RUNNING - high while counting is enabled
interface divided_tick_bcd_counter_if;
    logic       DIV_IN;
    logic       START;
    logic       STOP;
    logic       CLEAR;
    logic       UP;
    logic       TICK;
    logic [3:0] ONES;
    logic [3:0] TENS;
    logic       WRAP;
    logic       RUNNING;

    modport master (
        output DIV_IN, START, STOP, CLEAR, UP,
        input  TICK, ONES, TENS, WRAP, RUNNING
    );

    modport slave (
        input  DIV_IN, START, STOP, CLEAR, UP,
        output TICK, ONES, TENS, WRAP, RUNNING
    );
endinterface

// File: rtl/divided_tick_bcd_counter.sv
// Synchronizes the divider's slow square wave, turns each rising edge into a
// one-cycle tick and uses the tick to advance a two-digit BCD up/down counter
// under start/stop/clear control.
// Ports:
//   CLK   - system clock, rising edge
//   RESET - asynchronous, active-high reset
//   bus   - slave side of divided_tick_bcd_counter_if (controls in, tick/digits/status out)
module divided_tick_bcd_counter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_TENS    = 5,
    parameter int unsigned MAX_ONES    = 9
) (
    input  logic                      CLK,
    input  logic                      RESET,
    divided_tick_bcd_counter_if.slave bus
);

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] ONES_LIMIT = DIGIT_W'(MAX_ONES);
    localparam logic [DIGIT_W-1:0] TENS_LIMIT = DIGIT_W'(MAX_TENS);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   prev_q;
    logic                   tick_q;
    state_t                 state_q;
    logic                   running_q;
    logic [DIGIT_W-1:0]     ones_q;
    logic [DIGIT_W-1:0]     tens_q;
    logic                   wrap_q;
    logic                   count_en_c;

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Synchronizer chain, edge history and registered rising-edge tick.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.DIV_IN};
            prev_q <= sync_out;
            tick_q <= sync_out & ~prev_q;
        end
    end

    // Run/stop FSM; STOP dominates a simultaneous START.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_STOPPED;
            running_q <= 1'b0;
        end else begin
            case (state_q)
                ST_STOPPED: begin
                    if (bus.START && !bus.STOP) begin
                        state_q   <= ST_RUNNING;
                        running_q <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (bus.STOP) begin
                        state_q   <= ST_STOPPED;
                        running_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_STOPPED;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    // Registered tick and run flag gate counting, so a START landing on a tick
    // misses it while a STOP landing on a tick still counts it.
    assign count_en_c = tick_q & running_q;

    // BCD digits with wrap pulse; CLEAR overrides a simultaneous count.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ones_q <= '0;
            tens_q <= '0;
            wrap_q <= 1'b0;
        end else if (bus.CLEAR) begin
            ones_q <= '0;
            tens_q <= '0;
            wrap_q <= 1'b0;
        end else if (count_en_c) begin
            wrap_q <= 1'b0;
            if (bus.UP) begin
                if (ones_q < ONES_LIMIT) begin
                    ones_q <= ones_q + DIGIT_W'(1);
                end else if (tens_q >= TENS_LIMIT) begin
                    ones_q <= '0;
                    tens_q <= '0;
                    wrap_q <= 1'b1;
                end else begin
                    ones_q <= '0;
                    tens_q <= tens_q + DIGIT_W'(1);
                end
            end else begin
                if (ones_q != '0) begin
                    ones_q <= ones_q - DIGIT_W'(1);
                end else if (tens_q == '0) begin
                    ones_q <= ONES_LIMIT;
                    tens_q <= TENS_LIMIT;
                    wrap_q <= 1'b1;
                end else begin
                    ones_q <= ONES_LIMIT;
                    tens_q <= tens_q - DIGIT_W'(1);
                end
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign bus.TICK    = tick_q;
    assign bus.ONES    = ones_q;
    assign bus.TENS    = tens_q;
    assign bus.WRAP    = wrap_q;
    assign bus.RUNNING = running_q;

endmodule
